// File: rtl/pulse_period_checker.sv
// Lock-and-check monitor for a periodic one-hot strobe: acquires period/phase, then flags early and missing pulses.
// The "pulse due" output is named expect_pulse because expect is a reserved SystemVerilog keyword.
module pulse_period_checker #(
  parameter int PERIOD = 3,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             expect_pulse
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(PERIOD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] good, good_n;
  logic err_n;
  logic on_time, early, missing;

  assign on_time = pulse_in && (cnt == CNT_FULL);
  assign early   = pulse_in && (cnt != CNT_FULL);
  assign missing = !pulse_in && (cnt == CNT_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      cnt       <= '0;
      good      <= '0;
      err       <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      good   <= good_n;
      err    <= err_n;
      locked <= (state_n == LOCKED);
      // Clear beats a coincident increment; the err pulse itself still fires.
      if (err_clr)
        err_count <= '0;
      else if (err_n && err_count != ERR_MAX)
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_ONE;
    good_n  = good;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        cnt_n = '0;
        if (pulse_in) begin
          state_n = ACQ;
          cnt_n   = CNT_ONE;
          good_n  = '0;
        end
      end
      ACQ: begin
        if (on_time) begin
          cnt_n = CNT_ONE;
          if (good == GOOD_LAST) begin
            state_n = LOCKED;
            good_n  = '0;
          end else begin
            good_n = good + 1'b1;
          end
        end else if (early) begin
          cnt_n  = CNT_ONE;
          good_n = '0;
        end else if (missing) begin
          state_n = SEARCH;
          cnt_n   = '0;
          good_n  = '0;
        end
      end
      LOCKED: begin
        if (on_time) begin
          cnt_n = CNT_ONE;
        end else if (early) begin
          err_n   = 1'b1;
          state_n = ACQ;
          cnt_n   = CNT_ONE;
          good_n  = '0;
        end else if (missing) begin
          err_n   = 1'b1;
          state_n = SEARCH;
          cnt_n   = '0;
          good_n  = '0;
        end
      end
      default: begin
        state_n = SEARCH;
        cnt_n   = '0;
        good_n  = '0;
      end
    endcase
  end

  assign expect_pulse = (state == LOCKED) && (cnt == CNT_FULL);

endmodule
